// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: timestamps trigger pulses as {epoch, count} and queues them in a FWFT FIFO.
// Latency: a trigger sampled at edge N is visible on rd_data/rd_valid right after edge N.
// Backpressure: rd_ready low lets the FIFO fill; triggers while full (no same-edge pop) are dropped and flagged.
//
// Ports:
//   clk, reset (async active-low)   - clock and reset
//   count_in [CNT_W]                - free-running counter value, sampled every cycle
//   trigger                         - capture request, level-sampled per cycle
//   rd_ready / rd_valid / rd_data   - valid/ready read port, rd_data = {epoch, count}
//   level, full                     - occupancy, 0..DEPTH
//   clear_ovf, overflow, drop_cnt   - sticky drop flag, its clear, and the dropped-trigger counter
//
// Build option: define SNAP_DROP_CNT_EN to get a saturating 8-bit drop counter;
// without it drop_cnt is tied to 0.

module count_snapshot_fifo #(
  parameter  int CNT_W   = 8,
  parameter  int EPOCH_W = 8,
  parameter  int DEPTH   = 8,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CNT_W-1:0]           count_in,
  input  logic                       trigger,
  input  logic                       rd_ready,
  input  logic                       clear_ovf,
  output logic                       rd_valid,
  output logic [EPOCH_W+CNT_W-1:0]   rd_data,
  output logic [LW-1:0]              level,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [CNT_W-1:0]   count;
  } snap_t;

  logic [CNT_W-1:0]   prev_cnt;
  logic [EPOCH_W-1:0] epoch;
  logic [EPOCH_W-1:0] epoch_next;
  logic               wrap;

  logic [LW-1:0]      wr_ptr;
  logic [LW-1:0]      rd_ptr;
  snap_t              mem [DEPTH];

  logic               push;
  logic               pop;
  logic               drop;

  // A decreasing count means the upstream counter rolled over; equal values
  // (counter held) are deliberately not a wrap.
  assign wrap       = (count_in < prev_cnt);
  assign epoch_next = epoch + EPOCH_W'(wrap);

  // All status outputs derive from registered pointers only, so nothing on
  // trigger/count_in reaches an output combinationally.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == LW'(DEPTH));
  assign rd_valid = (wr_ptr != rd_ptr);
  assign rd_data  = mem[rd_ptr[LW-2:0]];

  assign pop  = rd_valid & rd_ready;
  // A same-edge pop frees the slot, so a full FIFO can still accept the push.
  assign push = trigger & (~full | pop);
  assign drop = trigger & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cnt <= '0;
      epoch    <= '0;
    end else begin
      prev_cnt <= count_in;
      epoch    <= epoch_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[LW-2:0]] <= '{epoch: epoch_next, count: count_in};
    end
  end

  // Set has priority over clear so a drop on the clearing edge is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef SNAP_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (clear_ovf) begin
      // Clear restarts the count, counting a drop on the same edge.
      drop_q <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_count_snapshot_fifo.sv
module tb_count_snapshot_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  count_in;
  logic        trigger;
  logic        rd_ready;
  logic        clear_ovf;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb [$];

`ifdef SNAP_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  count_snapshot_fifo #(.CNT_W(8), .EPOCH_W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .trigger   (trigger),
    .rd_ready  (rd_ready),
    .clear_ovf (clear_ovf),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable from #1 after the rising edge, so a handshake
  // seen on the falling edge is exactly the pop the next rising edge performs.
  always @(negedge clk) begin
    if (reset === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data_unexpected: got 0x%0h, expected no entry (t=%0t)", rd_data, $time);
      end else begin
        check("rd_data", {16'h0, rd_data}, {16'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    count_in  = 8'd0;
    trigger   = 1'b0;
    rd_ready  = 1'b0;
    clear_ovf = 1'b0;

    // Reset state and idle
    tick();
    tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_level",    level,    0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_rd_valid", rd_valid, 0);
    check("idle_level",    level,    0);
    check("idle_full",     full,     0);
    check("idle_overflow", overflow, 0);
    check("idle_drop_cnt", drop_cnt, 0);

    // Counting 0..255, 0..5 with captures at 10 and (after wrap) 3
    rd_ready = 1'b1;
    for (int v = 0; v < 262; v++) begin
      count_in = (v < 256) ? 8'(v) : 8'(v - 256);
      trigger  = (v == 10) || (v == 259);
      if (v == 10)  sb.push_back(16'h000A);
      if (v == 259) sb.push_back(16'h0103);
      tick();
    end
    trigger = 1'b0;
    repeat (3) tick();
    check("count_drained", sb.size(), 0);

    // Wrap and capture on the same edge, from a fresh epoch
    reset = 1'b0;
    #1;
    sb.delete();
    tick();
    reset    = 1'b1;
    count_in = 8'd255;
    tick();
    count_in = 8'd0;
    trigger  = 1'b1;
    sb.push_back(16'h0100);
    tick();
    trigger = 1'b0;
    repeat (2) tick();
    check("wrap_cap_drained", sb.size(), 0);

    // Fill with 9 triggers, no reads: 8 stored, 1 dropped
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      count_in = 8'(20 + i);
      trigger  = 1'b1;
      if (i < 8) sb.push_back(16'h0100 | 16'(20 + i));
      tick();
    end
    trigger = 1'b0;
    check("fill_level",    level,    8);
    check("fill_full",     full,     1);
    check("fill_overflow", overflow, 1);
    check("fill_drop_cnt", drop_cnt, DC_EN ? 1 : 0);

    // Full with simultaneous push and pop
    count_in = 8'd30;
    trigger  = 1'b1;
    rd_ready = 1'b1;
    sb.push_back(16'h011E);
    tick();
    trigger  = 1'b0;
    rd_ready = 1'b0;
    check("pp_level",    level,    8);
    check("pp_full",     full,     1);
    check("pp_overflow", overflow, 1);
    check("pp_drop_cnt", drop_cnt, DC_EN ? 1 : 0);

    // clear_ovf alone, then clear_ovf with a drop on the same edge
    clear_ovf = 1'b1;
    tick();
    check("clr_overflow", overflow, 0);
    check("clr_drop_cnt", drop_cnt, 0);
    count_in = 8'd31;
    trigger  = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clrdrop_overflow", overflow, 1);
    check("clrdrop_drop_cnt", drop_cnt, DC_EN ? 1 : 0);
    check("clrdrop_level",    level,    8);

    // Drop counter saturation
    repeat (260) tick();
    trigger = 1'b0;
    check("sat_drop_cnt", drop_cnt, DC_EN ? 255 : 0);
    check("sat_level",    level,    8);

    // Drain: original entries 2..8 then the appended one
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && rd_valid; i++) tick();
    check("drain_rd_valid", rd_valid, 0);
    check("drain_level",    level,    0);
    check("drain_full",     full,     0);
    check("drain_sb_empty", sb.size(), 0);

    // Reset mid-stream with 5 entries
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      count_in = 8'(40 + i);
      trigger  = 1'b1;
      sb.push_back(16'h0100 | 16'(40 + i));
      tick();
    end
    trigger = 1'b0;
    check("mid_level", level, 5);
    reset = 1'b0;
    #1;
    check("mid_rst_level",    level,    0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    sb.delete();
    repeat (2) tick();
    reset    = 1'b1;
    count_in = 8'd7;
    trigger  = 1'b1;
    rd_ready = 1'b1;
    sb.push_back(16'h0007);
    tick();

    // Back-to-back push and pop every cycle
    for (int i = 0; i < 10; i++) begin
      count_in = 8'(50 + i);
      sb.push_back(16'(50 + i));
      tick();
      check("stream_level", level, 1);
    end
    trigger = 1'b0;
    repeat (3) tick();
    check("stream_level_end", level, 0);
    check("stream_sb_empty",  sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
